neuron_mac_0_14_7: RTL and testbench

// - Downstream consumer of one 28x16b weight BRAM (neuron 7 of layer-0 group 14): streams 28 activations,

---
 rtl/neuron_mac_0_14_7_pkg.sv | 21 ++
 rtl/neuron_mac_0_14_7_if.sv | 29 ++
 rtl/neuron_mac_0_14_7_sat.sv | 33 +++
 rtl/neuron_mac_0_14_7.sv | 127 ++++++++++++
 tb/tb_neuron_mac_0_14_7.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/neuron_mac_0_14_7_pkg.sv
// rtl/neuron_mac_0_14_7_pkg.sv - shared fixed-point constants and FSM encoding for the neuron MAC
package neuron_mac_0_14_7_pkg;

  localparam int DATA_W      = 16;
  localparam int FRAC_BITS_D = 8;
  localparam int ACC_W_D     = 40;
  localparam int N_IN_D      = 28;
  localparam int W_ADDR_W    = 5;

  localparam int SAT_MAX = (1 <<< (DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(1 <<< (DATA_W - 1));

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_TAIL = 3'd2,
    ST_BIAS = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/neuron_mac_0_14_7_if.sv
// rtl/neuron_mac_0_14_7_if.sv - control, activation stream, weight BRAM and result handshake bundle
interface neuron_mac_0_14_7_if;
  import neuron_mac_0_14_7_pkg::*;

  logic                start;
  logic [DATA_W-1:0]   bias;
  logic                busy;
  logic [DATA_W-1:0]   x_in;
  logic                x_valid;
  logic                x_ready;
  logic [W_ADDR_W-1:0] w_addr;
  logic                w_en;
  logic                w_we;
  logic [DATA_W-1:0]   w_do;
  logic [DATA_W-1:0]   y_out;
  logic                y_valid;
  logic                y_ready;

  modport slave (
    input  start, bias, x_in, x_valid, w_do, y_ready,
    output busy, x_ready, w_addr, w_en, w_we, y_out, y_valid
  );

  modport master (
    output start, bias, x_in, x_valid, w_do, y_ready,
    input  busy, x_ready, w_addr, w_en, w_we, y_out, y_valid
  );

endinterface

// File: rtl/neuron_mac_0_14_7_sat.sv
// rtl/neuron_mac_0_14_7_sat.sv - drop fraction bits of the accumulator, saturate, optional ReLU
module fxp_sat_relu
  import neuron_mac_0_14_7_pkg::*;
#(
  parameter int ACC_W     = ACC_W_D,
  parameter int FRAC_BITS = FRAC_BITS_D,
  parameter bit RELU      = 1'b1
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic [DATA_W-1:0]       y_o
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] r;

  // Arithmetic shift floors toward -inf, matching the Q-format truncation rule.
  assign r = acc_i >>> FRAC_BITS;

  always_comb begin
    y_o = r[DATA_W-1:0];
    if (r > HI) begin
      y_o = DATA_W'(SAT_MAX);
    end else if (r < LO) begin
      y_o = DATA_W'(SAT_MIN);
    end
    if (RELU && r[ACC_W-1]) begin
      y_o = '0;
    end
  end

endmodule

// File: rtl/neuron_mac_0_14_7.sv
// rtl/neuron_mac_0_14_7.sv - streams N_IN activations against one weight BRAM, accumulates, adds bias, emits one output
module neuron_mac_0_14_7
  import neuron_mac_0_14_7_pkg::*;
#(
  parameter int N_IN      = N_IN_D,
  parameter int FRAC_BITS = FRAC_BITS_D,
  parameter int ACC_W     = ACC_W_D,
  parameter bit RELU      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  neuron_mac_0_14_7_if.slave     bus
);

  localparam logic [W_ADDR_W-1:0] LAST = W_ADDR_W'(N_IN - 1);
  localparam int                  PW   = 2 * DATA_W;

  state_t                     state_q, state_d;
  logic [W_ADDR_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [PW-1:0]       prod_q, prod_d;
  logic                       pv_q, pv_d;
  logic signed [DATA_W-1:0]   bias_q, bias_d;
  logic [DATA_W-1:0]          y_q, y_d;
  logic                       yv_q, yv_d;
  logic [DATA_W-1:0]          sat_y;
  logic                       xfer;

  assign xfer = bus.x_valid && (state_q == ST_RUN);

  fxp_sat_relu #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS),
    .RELU      (RELU)
  ) u_sat (
    .acc_i (acc_q),
    .y_o   (sat_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      bias_q  <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
      bias_q  <= bias_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (xfer && cnt_q == LAST) state_d = ST_TAIL;
      ST_TAIL: state_d = ST_BIAS;
      ST_BIAS: state_d = ST_OUT;
      ST_OUT:  if (yv_q && bus.y_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: the product of one transfer is folded into acc on the following edge,
  // overlapping with the next transfer, so TAIL only drains the last product.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    prod_d = prod_q;
    pv_d   = 1'b0;
    bias_d = bias_q;
    y_d    = y_q;
    yv_d   = yv_q;
    if (pv_q) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d  = '0;
          acc_d  = '0;
          bias_d = bus.bias;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          prod_d = PW'($signed(bus.x_in)) * PW'($signed(bus.w_do));
          pv_d   = 1'b1;
          cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + W_ADDR_W'(1);
        end
      end
      ST_BIAS: begin
        acc_d = acc_d + (ACC_W'(bias_q) <<< FRAC_BITS);
      end
      ST_OUT: begin
        if (!yv_q) begin
          y_d  = sat_y;
          yv_d = 1'b1;
        end else if (bus.y_ready) begin
          yv_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != ST_IDLE);
    bus.x_ready = (state_q == ST_RUN);
    bus.w_en    = (state_q == ST_RUN);
    bus.w_we    = 1'b0;
    bus.w_addr  = cnt_q;
    bus.y_out   = y_q;
    bus.y_valid = yv_q;
  end

endmodule

// File: tb/tb_neuron_mac_0_14_7.sv
// tb/tb_neuron_mac_0_14_7.sv - randomized self-checking bench, ReLU and linear instances side by side
module tb_neuron_mac_0_14_7;
  import neuron_mac_0_14_7_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_mac_0_14_7_if b0 ();
  neuron_mac_0_14_7_if b1 ();

  assign b1.start   = b0.start;
  assign b1.bias    = b0.bias;
  assign b1.x_in    = b0.x_in;
  assign b1.x_valid = b0.x_valid;
  assign b1.y_ready = b0.y_ready;

  neuron_mac_0_14_7 #(.RELU(1'b1)) dut_relu (.clk(clk), .rst(rst), .bus(b0));
  neuron_mac_0_14_7 #(.RELU(1'b0)) dut_lin  (.clk(clk), .rst(rst), .bus(b1));

  logic [15:0] wmem [32];
  logic [15:0] xs [28];
  logic [15:0] bias_v;

  always @(negedge clk) if (b0.w_en) b0.w_do <= wmem[b0.w_addr];
  always @(negedge clk) if (b1.w_en) b1.w_do <= wmem[b1.w_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input bit relu);
    longint s;
    longint r;
    s = 0;
    for (int i = 0; i < 28; i++) s += longint'($signed(xs[i])) * longint'($signed(wmem[i]));
    s += longint'($signed(bias_v)) * 256;
    r = s >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  task automatic fill(input logic [15:0] w, input logic [15:0] x, input logic [15:0] b);
    for (int i = 0; i < 32; i++) wmem[i] = w;
    for (int i = 0; i < 28; i++) xs[i] = x;
    bias_v = b;
  endtask

  task automatic run(input string tag, input int gap_pct, input int hold, input bit poke,
                     output logic [15:0] y0, output logic [15:0] y1);
    int idx, last_edge, addr_err, guard, stab_err;
    logic xr;
    logic [4:0] wa;
    idx = 0; last_edge = 0; addr_err = 0; guard = 0; stab_err = 0;
    @(posedge clk); #1;
    b0.bias = bias_v; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    check({tag, "_busy_start"}, {31'd0, b0.busy}, 32'd1);
    while (idx < 28 && guard < 2000) begin
      guard++;
      b0.x_valid = ($urandom_range(0, 99) >= gap_pct);
      b0.x_in    = xs[idx];
      if (poke && idx == 5) begin
        b0.start = 1'b1; b0.bias = ~bias_v;
      end else begin
        b0.start = 1'b0; b0.bias = bias_v;
      end
      @(negedge clk);
      xr = b0.x_ready;
      wa = b0.w_addr;
      @(posedge clk); #1;
      if (b0.x_valid && xr) begin
        if (wa != 5'(idx)) addr_err++;
        idx++;
        last_edge = cyc;
      end
    end
    b0.x_valid = 1'b0; b0.start = 1'b0; b0.bias = bias_v;
    check({tag, "_xfers"}, idx, 28);
    check({tag, "_waddr_walk"}, addr_err, 0);
    guard = 0;
    while (!b0.y_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_latency"}, cyc - last_edge, 3);
    check({tag, "_yv_lin"}, {31'd0, b1.y_valid}, 32'd1);
    y0 = b0.y_out;
    y1 = b1.y_out;
    check({tag, "_y_relu"}, y0, model(1'b1));
    check({tag, "_y_lin"}, y1, model(1'b0));
    for (int k = 0; k < hold; k++) begin
      b0.start = (poke && k == 2);
      @(posedge clk); #1;
      if (b0.y_out !== y0 || b1.y_out !== y1 || !b0.y_valid || !b0.busy) stab_err++;
    end
    b0.start = 1'b0;
    if (hold > 0) check({tag, "_hold_stable"}, stab_err, 0);
    b0.y_ready = 1'b1;
    b0.start   = 1'b1;
    @(posedge clk); #1;
    b0.y_ready = 1'b0;
    b0.start   = 1'b0;
    check({tag, "_done"}, {28'd0, b0.y_valid, b0.busy, b1.y_valid, b1.busy}, 32'd0);
  endtask

  logic [15:0] r0, r1;

  initial begin
    rst = 1'b1;
    b0.start = 1'b0; b0.bias = '0; b0.x_in = '0; b0.x_valid = 1'b0; b0.y_ready = 1'b0;
    fill(16'h0100, 16'h0100, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {b0.busy, b0.x_ready, b0.w_en, b0.w_we, b0.y_valid, b0.w_addr, b0.y_out}, 32'd0);
    rst = 1'b0;

    run("ones", 0, 0, 1'b0, r0, r1);
    check("ones_const", r0, 16'h1C00);

    run("ones_gap", 50, 0, 1'b0, r0, r1);
    check("ones_gap_const", r0, 16'h1C00);

    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run("sat_pos", 0, 0, 1'b0, r0, r1);
    check("sat_pos_const", r1, 16'h7FFF);

    fill(16'h0100, 16'hFF00, 16'h0200);
    run("neg", 0, 0, 1'b0, r0, r1);
    check("neg_relu_const", r0, 16'h0000);
    check("neg_lin_const", r1, 16'hE600);

    fill(16'h0100, 16'h0100, 16'h0000);
    run("hold_poke", 30, 10, 1'b1, r0, r1);

    // Abort mid-stream with an asynchronous reset, then verify a clean restart.
    @(posedge clk); #1;
    b0.start = 1'b1; b0.bias = 16'h0000;
    @(posedge clk); #1;
    b0.start = 1'b0; b0.x_valid = 1'b1; b0.x_in = 16'h0100;
    repeat (10) @(posedge clk);
    #2;
    b0.x_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset", {b0.busy, b0.x_ready, b0.w_en, b0.w_we, b0.y_valid, b0.w_addr, b0.y_out,
                          b1.busy, b1.y_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run("after_rst", 0, 0, 1'b0, r0, r1);
    check("after_rst_const", r0, 16'h1C00);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++)
        wmem[i] = (t % 2 == 0) ? 16'($urandom_range(0, 2047) - 1024) : 16'($urandom);
      for (int i = 0; i < 28; i++)
        xs[i] = (t % 2 == 0) ? 16'($urandom_range(0, 2047) - 1024) : 16'($urandom);
      bias_v = 16'($urandom);
      run($sformatf("rand%0d", t), $urandom_range(0, 60), $urandom_range(0, 4), t[0], r0, r1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
